// File: rtl/nabu_video_timing_if.sv
// Video timing bundle: mode/pattern controls in, pixel enable, counters, flags, colour out.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer samples on ce_pix and cannot stall the raster.
//
// master: the generator (reads pal/scandouble/pattern, drives the rest).
// slave : the video sink (drives the controls, reads timing and colour).
interface nabu_video_timing_if #(
    parameter int COLOR_W = 8,
    parameter int CNT_W   = 10
);
    logic               pal;
    logic               scandouble;
    logic [1:0]         pattern;
    logic               ce_pix;
    logic [CNT_W-1:0]   hcnt;
    logic [CNT_W-1:0]   vcnt;
    logic               HBlank;
    logic               HSync;
    logic               VBlank;
    logic               VSync;
    logic               frame_start;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;

    modport master (
        input  pal, scandouble, pattern,
        output ce_pix, hcnt, vcnt, HBlank, HSync, VBlank, VSync, frame_start, r, g, b
    );

    modport slave (
        output pal, scandouble, pattern,
        input  ce_pix, hcnt, vcnt, HBlank, HSync, VBlank, VSync, frame_start, r, g, b
    );
endinterface

// File: rtl/nabu_video_timing.sv
// Video timing + test-pattern generator (pixel enable, H/V counters, blank/sync, RGB patterns).
// Latency: all outputs registered; counters, flags and colour change on the edge that raises ce_pix.
// Backpressure: none; free-running raster, mode inputs only take effect at the frame boundary.
//
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset
//   vid   - nabu_video_timing_if.master: pal/scandouble/pattern in; ce_pix, hcnt, vcnt,
//           HBlank/HSync/VBlank/VSync, frame_start, r/g/b out
// Optional feature: define NABU_VTIMING_NOISE_EN to build the LFSR noise source for pattern 0;
// otherwise pattern 0 is a grey ramp of hcnt.
module nabu_video_timing #(
    parameter int CE_DIV    = 8,
    parameter int COLOR_W   = 8,
    parameter int CNT_W     = 10,
    parameter int H_ACTIVE  = 256,
    parameter int H_FP      = 14,
    parameter int H_SYNC    = 26,
    parameter int H_BP      = 46,
    parameter int V_ACTIVE  = 192,
    parameter int V_SYNC    = 3,
    parameter int VN_FP     = 24,
    parameter int VN_BP     = 43,
    parameter int VP_FP     = 48,
    parameter int VP_BP     = 70,
    parameter int BAR_SHIFT = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    nabu_video_timing_if.master   vid
);
    localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VN_TOT = V_ACTIVE + VN_FP + V_SYNC + VN_BP;
    localparam int VP_TOT = V_ACTIVE + VP_FP + V_SYNC + VP_BP;
    localparam int DIV_W  = $clog2(CE_DIV);
    localparam logic [COLOR_W-1:0] C_MAX   = '1;
    localparam logic [COLOR_W-1:0] C_SOLID = COLOR_W'(1) << (COLOR_W - 1);

    logic [DIV_W-1:0]   r_div;
    logic [CNT_W-1:0]   r_hcnt, r_vcnt;
    logic               r_pal, r_sd, r_line_odd;
    logic               r_ce, r_frame_start;
    logic               r_hblank, r_hsync, r_vblank, r_vsync;
    logic [COLOR_W-1:0] r_r, r_g, r_b;

    logic [DIV_W-1:0]   w_div_max;
    logic               w_div_last, w_hwrap, w_vlast, w_vstep, w_frame;
    logic [CNT_W-1:0]   w_hnext, w_vnext, w_vs_beg, w_vs_end;
    logic               w_hblank, w_hsync, w_vblank, w_vsync;
    logic [2:0]         w_bar;
    logic [COLOR_W-1:0] w_r, w_g, w_b, w_pat0;

    // Divider terminal count: halved in scandouble so the line rate doubles.
    assign w_div_max  = r_sd ? DIV_W'(CE_DIV / 2 - 1) : DIV_W'(CE_DIV - 1);
    assign w_div_last = (r_div == w_div_max);

    assign w_hwrap = (r_hcnt == CNT_W'(H_TOT - 1));
    assign w_vlast = r_pal ? (r_vcnt == CNT_W'(VP_TOT - 1)) : (r_vcnt == CNT_W'(VN_TOT - 1));
    // In scandouble each line is scanned twice; vcnt only steps on the second pass.
    assign w_vstep = w_hwrap && (!r_sd || r_line_odd);
    assign w_frame = w_vstep && w_vlast;

    assign w_hnext = w_hwrap ? '0 : r_hcnt + 1'b1;
    assign w_vnext = !w_vstep ? r_vcnt : (w_vlast ? '0 : r_vcnt + 1'b1);

    // Flags are decoded from the values the counters are about to take, so they
    // land on the same edge as the counters. At the boundary vnext is 0, so using
    // the outgoing mode's porch here is harmless.
    assign w_vs_beg = r_pal ? CNT_W'(V_ACTIVE + VP_FP) : CNT_W'(V_ACTIVE + VN_FP);
    assign w_vs_end = w_vs_beg + CNT_W'(V_SYNC);
    assign w_hblank = (w_hnext >= CNT_W'(H_ACTIVE));
    assign w_hsync  = (w_hnext >= CNT_W'(H_ACTIVE + H_FP)) &&
                      (w_hnext <  CNT_W'(H_ACTIVE + H_FP + H_SYNC));
    assign w_vblank = (w_vnext >= CNT_W'(V_ACTIVE));
    assign w_vsync  = (w_vnext >= w_vs_beg) && (w_vnext < w_vs_end);

    // Bar 0 (left edge) is white, counting down to black on the right.
    assign w_bar = 3'd7 - w_hnext[BAR_SHIFT+2:BAR_SHIFT];

`ifdef NABU_VTIMING_NOISE_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_next;

    // Galois form, shift right, taps 16'hB400: maximal length (65535 states).
    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
    assign w_pat0      = COLOR_W'(w_lfsr_next);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else if (w_div_last) begin
            r_lfsr <= w_lfsr_next;
        end
    end
`else
    assign w_pat0 = COLOR_W'(w_hnext);
`endif

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (!(w_hblank || w_vblank)) begin
            case (vid.pattern)
                2'd0: begin
                    w_r = w_pat0;
                    w_g = w_pat0;
                    w_b = w_pat0;
                end
                2'd1: begin
                    w_r = w_bar[1] ? C_MAX : '0;
                    w_g = w_bar[2] ? C_MAX : '0;
                    w_b = w_bar[0] ? C_MAX : '0;
                end
                2'd2: begin
                    if (w_hnext[3:0] == 4'd0 || w_vnext[3:0] == 4'd0) begin
                        w_r = C_MAX;
                        w_g = C_MAX;
                        w_b = C_MAX;
                    end
                end
                default: begin
                    w_r = C_SOLID;
                    w_g = C_SOLID;
                    w_b = C_SOLID;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div         <= '0;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_pal         <= 1'b0;
            r_sd          <= 1'b0;
            r_line_odd    <= 1'b0;
            r_ce          <= 1'b0;
            r_frame_start <= 1'b0;
            r_hblank      <= 1'b0;
            r_hsync       <= 1'b0;
            r_vblank      <= 1'b0;
            r_vsync       <= 1'b0;
            r_r           <= '0;
            r_g           <= '0;
            r_b           <= '0;
        end else begin
            r_ce          <= 1'b0;
            r_frame_start <= 1'b0;
            if (w_div_last) begin
                r_div    <= '0;
                r_ce     <= 1'b1;
                r_hcnt   <= w_hnext;
                r_vcnt   <= w_vnext;
                r_hblank <= w_hblank;
                r_hsync  <= w_hsync;
                r_vblank <= w_vblank;
                r_vsync  <= w_vsync;
                r_r      <= w_r;
                r_g      <= w_g;
                r_b      <= w_b;
                if (w_frame) begin
                    // Mode switches only here, so a frame never mixes timings.
                    r_pal         <= vid.pal;
                    r_sd          <= vid.scandouble;
                    r_line_odd    <= 1'b0;
                    r_frame_start <= 1'b1;
                end else if (w_hwrap && r_sd) begin
                    r_line_odd <= ~r_line_odd;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign vid.ce_pix      = r_ce;
    assign vid.hcnt        = r_hcnt;
    assign vid.vcnt        = r_vcnt;
    assign vid.HBlank      = r_hblank;
    assign vid.HSync       = r_hsync;
    assign vid.VBlank      = r_vblank;
    assign vid.VSync       = r_vsync;
    assign vid.frame_start = r_frame_start;
    assign vid.r           = r_r;
    assign vid.g           = r_g;
    assign vid.b           = r_b;
endmodule
